// File: rtl/core2axi_pkg.sv
// core2axi_pkg: shared types, AXI encodings and parameter checks for the core-to-AXI bridge
package core2axi_pkg;

    typedef enum logic {RD = 1'b0, WR = 1'b1} dir_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    function automatic bit legal_data_width(int unsigned w);
        return w == 32 || w == 64 || w == 128;
    endfunction

endpackage

// File: rtl/core2axi_lane_fifo.sv
// core2axi_lane_fifo: in-order queue of 32-bit lane offsets for outstanding reads
module core2axi_lane_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr, rptr;
    logic [PW:0]      count;

    assign rdata = mem[rptr];
    assign full  = count == (PW+1)'(DEPTH);
    assign empty = count == '0;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + PW'(push);
            rptr  <= rptr + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/core2axi_mo.sv
// core2axi_mo: single-direction, multiple-outstanding bridge from a 32-bit core data port to AXI4
module core2axi_mo
    import core2axi_pkg::*;
#(
    parameter int AXI4_ADDRESS_WIDTH = 32,
    parameter int AXI4_DATA_WIDTH    = 64,
    parameter int AXI4_ID_WIDTH      = 16,
    parameter int AXI4_USER_WIDTH    = 10,
    parameter int MAX_OUTSTANDING    = 4,
    parameter int AXI_ID             = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          data_req_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    output logic                          data_err_o,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_i,
    input  logic                          data_we_i,
    input  logic [3:0]                    data_be_i,
    input  logic [31:0]                   data_wdata_i,
    output logic [31:0]                   data_rdata_o,
    output logic [AXI4_ID_WIDTH-1:0]      aw_id_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0] aw_addr_o,
    output logic [7:0]                    aw_len_o,
    output logic [2:0]                    aw_size_o,
    output logic [1:0]                    aw_burst_o,
    output logic                          aw_lock_o,
    output logic [3:0]                    aw_cache_o,
    output logic [2:0]                    aw_prot_o,
    output logic [3:0]                    aw_region_o,
    output logic [AXI4_USER_WIDTH-1:0]    aw_user_o,
    output logic [3:0]                    aw_qos_o,
    output logic                          aw_valid_o,
    input  logic                          aw_ready_i,
    output logic [AXI4_DATA_WIDTH-1:0]    w_data_o,
    output logic [AXI4_DATA_WIDTH/8-1:0]  w_strb_o,
    output logic                          w_last_o,
    output logic [AXI4_USER_WIDTH-1:0]    w_user_o,
    output logic                          w_valid_o,
    input  logic                          w_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      b_id_i,
    input  logic [1:0]                    b_resp_i,
    input  logic                          b_valid_i,
    input  logic [AXI4_USER_WIDTH-1:0]    b_user_i,
    output logic                          b_ready_o,
    output logic [AXI4_ID_WIDTH-1:0]      ar_id_o,
    output logic [AXI4_ADDRESS_WIDTH-1:0] ar_addr_o,
    output logic [7:0]                    ar_len_o,
    output logic [2:0]                    ar_size_o,
    output logic [1:0]                    ar_burst_o,
    output logic                          ar_lock_o,
    output logic [3:0]                    ar_cache_o,
    output logic [2:0]                    ar_prot_o,
    output logic [3:0]                    ar_region_o,
    output logic [AXI4_USER_WIDTH-1:0]    ar_user_o,
    output logic [3:0]                    ar_qos_o,
    output logic                          ar_valid_o,
    input  logic                          ar_ready_i,
    input  logic [AXI4_ID_WIDTH-1:0]      r_id_i,
    input  logic [AXI4_DATA_WIDTH-1:0]    r_data_i,
    input  logic [1:0]                    r_resp_i,
    input  logic                          r_last_i,
    input  logic [AXI4_USER_WIDTH-1:0]    r_user_i,
    input  logic                          r_valid_i,
    output logic                          r_ready_o
);

    localparam int LW  = $clog2(AXI4_DATA_WIDTH / 32);
    localparam int LWS = LW > 0 ? LW : 1;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW  = AXI4_DATA_WIDTH / 8;

    if (!legal_data_width(AXI4_DATA_WIDTH)) begin : g_bad_dw
        $error("core2axi_mo: AXI4_DATA_WIDTH must be 32, 64 or 128");
    end
    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 16 || (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_mo
        $error("core2axi_mo: MAX_OUTSTANDING must be a power of two in 2..16");
    end

    logic [CW-1:0]  cnt;
    dir_e           dir;
    logic           aw_done, w_done;
    logic           issuable, ar_hs, aw_hs, w_hs, wr_gnt, b_hs, r_hs;
    logic [LWS-1:0] req_lane, rsp_lane;
    logic           unused;

    // Traffic only flows in one direction at a time; a turnaround waits for the pipe to drain.
    assign issuable = rst_ni && data_req_i && cnt < CW'(MAX_OUTSTANDING) &&
                      (cnt == '0 || dir_e'(data_we_i) == dir);

    assign ar_valid_o = issuable && !data_we_i;
    assign aw_valid_o = issuable && data_we_i && !aw_done;
    assign w_valid_o  = issuable && data_we_i && !w_done;
    assign ar_hs      = ar_valid_o && ar_ready_i;
    assign aw_hs      = aw_valid_o && aw_ready_i;
    assign w_hs       = w_valid_o && w_ready_i;
    assign wr_gnt     = issuable && data_we_i && (aw_done || aw_hs) && (w_done || w_hs);
    assign data_gnt_o = ar_hs || wr_gnt;

    assign b_ready_o     = rst_ni && cnt != '0 && dir == WR;
    assign r_ready_o     = rst_ni && cnt != '0 && dir == RD;
    assign b_hs          = b_valid_i && b_ready_o;
    assign r_hs          = r_valid_i && r_ready_o;
    assign data_rvalid_o = b_hs || r_hs;
    assign data_err_o    = b_hs ? b_resp_i[1] : r_hs && r_resp_i[1];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt     <= '0;
            dir     <= RD;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            cnt     <= cnt + CW'(data_gnt_o) - CW'(data_rvalid_o);
            dir     <= data_gnt_o ? dir_e'(data_we_i) : dir;
            aw_done <= !wr_gnt && (aw_done || aw_hs);
            w_done  <= !wr_gnt && (w_done || w_hs);
        end
    end

    assign req_lane = LW > 0 ? data_addr_i[LWS+1:2] : '0;

    if (LW > 0) begin : g_fifo
        logic fifo_full, fifo_empty;
        core2axi_lane_fifo #(
            .DEPTH (MAX_OUTSTANDING),
            .WIDTH (LWS)
        ) u_lane_fifo (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .push   (ar_hs && !fifo_full),
            .pop    (r_hs && !fifo_empty),
            .wdata  (req_lane),
            .rdata  (rsp_lane),
            .full   (fifo_full),
            .empty  (fifo_empty)
        );
    end else begin : g_no_fifo
        assign rsp_lane = '0;
    end

    assign data_rdata_o = r_data_i[{rsp_lane, 5'b0} +: 32];
    assign w_data_o     = {(AXI4_DATA_WIDTH/32){data_wdata_i}};
    assign w_strb_o     = SW'(data_be_i) << {req_lane, 2'b0};
    assign w_last_o     = 1'b1;
    assign w_user_o     = '0;

    assign aw_id_o     = AXI4_ID_WIDTH'(AXI_ID);
    assign aw_addr_o   = data_addr_i;
    assign aw_len_o    = '0;
    assign aw_size_o   = AXI_SIZE_4B;
    assign aw_burst_o  = AXI_BURST_INCR;
    assign aw_lock_o   = 1'b0;
    assign aw_cache_o  = '0;
    assign aw_prot_o   = '0;
    assign aw_region_o = '0;
    assign aw_user_o   = '0;
    assign aw_qos_o    = '0;

    assign ar_id_o     = AXI4_ID_WIDTH'(AXI_ID);
    assign ar_addr_o   = data_addr_i;
    assign ar_len_o    = '0;
    assign ar_size_o   = AXI_SIZE_4B;
    assign ar_burst_o  = AXI_BURST_INCR;
    assign ar_lock_o   = 1'b0;
    assign ar_cache_o  = '0;
    assign ar_prot_o   = '0;
    assign ar_region_o = '0;
    assign ar_user_o   = '0;
    assign ar_qos_o    = '0;

    assign unused = ^{b_id_i, b_user_i, b_resp_i[0], r_id_i, r_resp_i[0], r_last_i, r_user_i};

endmodule
